traffic_mode_sequencer: RTL and testbench

//  Drives the 2-bit mode input of the 4-way traffic light controller from raw requests.

---
 rtl/traffic_mode_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_traffic_mode_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_mode_sequencer.sv
// Pedestrian/emergency request sequencer driving the traffic controller mode input.
// Optional safety fault detection on light/walk feedback is enabled by TMS_FAULT_DETECT_EN.
//
// state      | meaning
// S_IDLE     | normal mode, waiting for emergency or pending walk request
// S_PED_WAIT | pedestrian mode requested, waiting for controller walk ack
// S_PED_WALK | walk acknowledged, holding pedestrian mode for WALK_CYCLES
// S_GAP      | forced normal mode for MIN_GAP cycles after a walk or timeout
// S_EMERG    | emergency mode, held while requested plus EMERG_HOLD cycles
module traffic_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 20,
  parameter int ACK_TIMEOUT     = 16,
  parameter int MIN_GAP         = 30,
  parameter int EMERG_HOLD      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       emerg_req,
  input  logic       pedestrian_signal,
  input  logic [1:0] ns_light,
  input  logic [1:0] ew_light,
  output logic [1:0] mode,
  output logic       ped_pending,
  output logic       ped_done,
  output logic       ped_timeout,
  output logic       fault
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > WALK_CYCLES) ? DEBOUNCE_CYCLES : WALK_CYCLES;
  localparam int MAX_CD  = (ACK_TIMEOUT > MIN_GAP) ? ACK_TIMEOUT : MIN_GAP;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_P   = (MAX_ABCD > EMERG_HOLD) ? MAX_ABCD : EMERG_HOLD;
  localparam int CW      = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_FULL  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] WALK_LAST = CW'(WALK_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(MIN_GAP - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(EMERG_HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PED_WAIT,
    S_PED_WALK,
    S_GAP,
    S_EMERG
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CW-1:0] deb_cnt;
  logic [1:0]    sync_q;
  logic          ped_sync;
  logic          deb_fire;
  logic          done_nxt, timeout_nxt, pend_nxt;
  logic          force_emerg;

  function automatic logic [1:0] mode_of(state_t s);
    case (s)
      S_PED_WAIT, S_PED_WALK: return 2'b01;
      S_EMERG:                return 2'b10;
      default:                return 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], ped_req};
  end

  assign ped_sync = sync_q[1];

  // Counter parks at DEB_FULL while held so a held button fires exactly once.
  assign deb_fire = ped_sync && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 deb_cnt <= '0;
    else if (!ped_sync)         deb_cnt <= '0;
    else if (deb_cnt != DEB_FULL) deb_cnt <= deb_cnt + CNT_ONE;
  end

`ifdef TMS_FAULT_DETECT_EN
  logic fault_q, fault_hit;

  assign fault_hit = ((ns_light != 2'b00) && (ew_light != 2'b00)) ||
                     (pedestrian_signal && ((ns_light != 2'b00) || (ew_light != 2'b00))) ||
                     (ns_light == 2'b11) || (ew_light == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_q | fault_hit;
  end

  assign force_emerg = fault_hit | fault_q;
  assign fault       = fault_q;
`else
  logic unused_lights;
  assign unused_lights = ^{ns_light, ew_light};
  assign force_emerg   = 1'b0;
  assign fault         = 1'b0;
`endif

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_inc;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (ped_pending) state_nxt = S_PED_WAIT;
      end
      S_PED_WAIT: begin
        if (pedestrian_signal) begin
          state_nxt = S_PED_WALK;
          cnt_nxt   = '0;
        end else if (cnt == ACK_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_GAP;
          cnt_nxt     = '0;
        end
      end
      S_PED_WALK: begin
        if (cnt == WALK_LAST) begin
          done_nxt  = 1'b1;
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_EMERG: begin
        if (emerg_req) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Emergency preempts everything; an interrupted walk leaves the request pending.
    if (emerg_req || force_emerg) begin
      state_nxt   = S_EMERG;
      cnt_nxt     = '0;
      done_nxt    = 1'b0;
      timeout_nxt = 1'b0;
    end
  end

  always_comb begin
    pend_nxt = ped_pending;
    if (done_nxt || timeout_nxt) pend_nxt = 1'b0;
    else if (deb_fire)           pend_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mode        <= 2'b00;
      ped_pending <= 1'b0;
      ped_done    <= 1'b0;
      ped_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mode        <= mode_of(state_nxt);
      ped_pending <= pend_nxt;
      ped_done    <= done_nxt;
      ped_timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_mode_sequencer.sv
// Bench for traffic_mode_sequencer: debounce vector table plus scripted walk, timeout,
// emergency, async-reset and fault sequences checked through a cycle-stamped scoreboard.
module tb_traffic_mode_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ped_req;
  logic       emerg_req;
  logic       pedestrian_signal;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic [1:0] mode;
  logic       ped_pending;
  logic       ped_done;
  logic       ped_timeout;
  logic       fault;

  localparam int SIG_MODE = 0;
  localparam int SIG_PEND = 1;
  localparam int SIG_DONE = 2;
  localparam int SIG_TMO  = 3;
  localparam int SIG_FLT  = 4;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  typedef struct {
    int len;
    int exp_pend;
    int exp_mode;
  } deb_vec_t;

  exp_t     sb[$];
  deb_vec_t vecs[5];
  int       n_chk = 0;
  int       n_fail = 0;
  int       cyc = 0;

  traffic_mode_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ped_req           (ped_req),
    .emerg_req         (emerg_req),
    .pedestrian_signal (pedestrian_signal),
    .ns_light          (ns_light),
    .ew_light          (ew_light),
    .mode              (mode),
    .ped_pending       (ped_pending),
    .ped_done          (ped_done),
    .ped_timeout       (ped_timeout),
    .fault             (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int sample(int sig);
    case (sig)
      SIG_MODE: return int'(mode);
      SIG_PEND: return int'(ped_pending);
      SIG_DONE: return int'(ped_done);
      SIG_TMO:  return int'(ped_timeout);
      default:  return int'(fault);
    endcase
  endfunction

  function automatic void exp_at(int c, int sig, int val, string name);
    exp_t e;
    e.cyc = c; e.sig = sig; e.val = val; e.name = name;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          check(sb[i].name, sample(sb[i].sig), sb[i].val);
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    ped_req = 1'b0;
    emerg_req = 1'b0;
    pedestrian_signal = 1'b0;
    ns_light = 2'b00;
    ew_light = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m, w, g, c;

    rst_n = 1'b1;
    ped_req = 1'b0;
    emerg_req = 1'b0;
    pedestrian_signal = 1'b0;
    ns_light = 2'b00;
    ew_light = 2'b00;

    // T1: async reset takes effect with no clock edge
    #1 rst_n = 1'b0;
    #1;
    check("t1_mode_noclk", int'(mode), 0);
    check("t1_pend_noclk", int'(ped_pending), 0);
    check("t1_done_noclk", int'(ped_done), 0);
    check("t1_tmo_noclk", int'(ped_timeout), 0);
    check("t1_fault_noclk", int'(fault), 0);
    tick();
    tick();
    check("t1_mode_held", int'(mode), 0);
    check("t1_pend_held", int'(ped_pending), 0);
    rst_n = 1'b1;
    tick();

    // Debounce table: press length -> accepted or not
    vecs[0] = '{len: 1, exp_pend: 0, exp_mode: 0};
    vecs[1] = '{len: 3, exp_pend: 0, exp_mode: 0};
    vecs[2] = '{len: 4, exp_pend: 1, exp_mode: 1};
    vecs[3] = '{len: 6, exp_pend: 1, exp_mode: 1};
    vecs[4] = '{len: 8, exp_pend: 1, exp_mode: 1};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      tick();
      n0 = cyc;
      exp_at(n0 + 5, SIG_PEND, 0, $sformatf("deb%0d_pend_early", vecs[i].len));
      exp_at(n0 + 6, SIG_PEND, vecs[i].exp_pend, $sformatf("deb%0d_pend", vecs[i].len));
      exp_at(n0 + 6, SIG_MODE, 0, $sformatf("deb%0d_mode_pre", vecs[i].len));
      exp_at(n0 + 7, SIG_MODE, vecs[i].exp_mode, $sformatf("deb%0d_mode", vecs[i].len));
      exp_at(n0 + 10, SIG_PEND, vecs[i].exp_pend, $sformatf("deb%0d_pend_late", vecs[i].len));
      ped_req = 1'b1;
      repeat (vecs[i].len) tick();
      ped_req = 1'b0;
      run_to(n0 + 12);
    end

    // T2: full walk, gap, second press served after gap
    do_reset();
    tick();
    n0 = cyc; m = n0 + 7; w = m + 4; g = w + 20;
    exp_at(n0 + 6, SIG_PEND, 1, "t2_pend_set");
    exp_at(m, SIG_MODE, 1, "t2_mode_ped");
    exp_at(w + 10, SIG_MODE, 1, "t2_mode_walk_mid");
    exp_at(w + 19, SIG_MODE, 1, "t2_mode_walk_last");
    exp_at(w + 19, SIG_DONE, 0, "t2_done_early");
    exp_at(g, SIG_DONE, 1, "t2_done_pulse");
    exp_at(g, SIG_PEND, 0, "t2_pend_clear");
    exp_at(g, SIG_MODE, 0, "t2_mode_gap");
    exp_at(g + 1, SIG_DONE, 0, "t2_done_width");
    exp_at(g + 15, SIG_MODE, 0, "t2_mode_gap_mid");
    exp_at(g + 10, SIG_PEND, 0, "t2_pend2_early");
    exp_at(g + 11, SIG_PEND, 1, "t2_pend2_set");
    exp_at(g + 30, SIG_MODE, 0, "t2_mode_gap_end");
    exp_at(g + 31, SIG_MODE, 1, "t2_mode_reserve");
    exp_at(g + 31, SIG_PEND, 1, "t2_pend_reserve");
    ped_req = 1'b1;
    run_to(n0 + 8);
    ped_req = 1'b0;
    run_to(m + 3);
    pedestrian_signal = 1'b1;
    run_to(w + 5);
    pedestrian_signal = 1'b0;
    run_to(g + 5);
    ped_req = 1'b1;
    run_to(g + 11);
    ped_req = 1'b0;
    run_to(g + 33);

    // T3: ack timeout with button still held
    do_reset();
    tick();
    n0 = cyc; m = n0 + 7;
    exp_at(m, SIG_MODE, 1, "t3_mode_ped");
    exp_at(m + 15, SIG_TMO, 0, "t3_tmo_early");
    exp_at(m + 15, SIG_PEND, 1, "t3_pend_waiting");
    exp_at(m + 15, SIG_MODE, 1, "t3_mode_waiting");
    exp_at(m + 16, SIG_TMO, 1, "t3_tmo_pulse");
    exp_at(m + 16, SIG_PEND, 0, "t3_pend_clear");
    exp_at(m + 16, SIG_MODE, 0, "t3_mode_gap");
    exp_at(m + 17, SIG_TMO, 0, "t3_tmo_width");
    exp_at(m + 20, SIG_PEND, 0, "t3_held_no_rearm");
    exp_at(m + 28, SIG_PEND, 0, "t3_release_no_req");
    ped_req = 1'b1;
    run_to(n0 + 30);
    ped_req = 1'b0;
    run_to(m + 30);

    // T4: emergency preempts walk; hold restarts on re-rise; walk re-served
    do_reset();
    tick();
    n0 = cyc; m = n0 + 7; w = m + 1;
    exp_at(w + 9, SIG_MODE, 1, "t4_mode_walk");
    exp_at(w + 10, SIG_MODE, 2, "t4_mode_emerg");
    exp_at(w + 10, SIG_PEND, 1, "t4_pend_kept");
    exp_at(w + 20, SIG_DONE, 0, "t4_no_done");
    exp_at(w + 22, SIG_MODE, 2, "t4_hold_restarted");
    exp_at(w + 25, SIG_MODE, 2, "t4_hold_last");
    exp_at(w + 26, SIG_MODE, 0, "t4_mode_idle");
    exp_at(w + 27, SIG_MODE, 1, "t4_mode_reserve");
    exp_at(w + 27, SIG_PEND, 1, "t4_pend_reserve");
    ped_req = 1'b1;
    run_to(n0 + 5);
    ped_req = 1'b0;
    run_to(m);
    pedestrian_signal = 1'b1;
    run_to(w + 9);
    emerg_req = 1'b1;
    run_to(w + 10);
    pedestrian_signal = 1'b0;
    run_to(w + 14);
    emerg_req = 1'b0;
    run_to(w + 17);
    emerg_req = 1'b1;
    run_to(w + 18);
    emerg_req = 1'b0;
    run_to(w + 30);

    // T4b: emergency coincides with debounce completion
    do_reset();
    tick();
    n0 = cyc;
    exp_at(n0 + 6, SIG_MODE, 2, "t4b_mode_emerg");
    exp_at(n0 + 6, SIG_PEND, 1, "t4b_pend_set");
    exp_at(n0 + 13, SIG_MODE, 2, "t4b_hold_last");
    exp_at(n0 + 14, SIG_MODE, 0, "t4b_mode_idle");
    exp_at(n0 + 15, SIG_MODE, 1, "t4b_mode_served");
    ped_req = 1'b1;
    run_to(n0 + 5);
    emerg_req = 1'b1;
    run_to(n0 + 6);
    emerg_req = 1'b0;
    run_to(n0 + 8);
    ped_req = 1'b0;
    run_to(n0 + 17);

    // T5: async reset between edges mid-walk
    do_reset();
    tick();
    n0 = cyc; m = n0 + 7; w = m + 1;
    exp_at(w + 4, SIG_MODE, 1, "t5_mode_walk");
    ped_req = 1'b1;
    run_to(n0 + 5);
    ped_req = 1'b0;
    run_to(m);
    pedestrian_signal = 1'b1;
    run_to(w + 5);
    #3 rst_n = 1'b0;
    #1;
    check("t5_mode_async", int'(mode), 0);
    check("t5_pend_async", int'(ped_pending), 0);
    pedestrian_signal = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    c = cyc;
    exp_at(c + 10, SIG_MODE, 0, "t5_mode_after");
    exp_at(c + 10, SIG_PEND, 0, "t5_pend_lost");
    run_to(c + 12);

    // T6: conflicting lights
    do_reset();
    tick();
    c = cyc;
`ifdef TMS_FAULT_DETECT_EN
    exp_at(c + 1, SIG_FLT, 1, "t6_fault_set");
    exp_at(c + 1, SIG_MODE, 2, "t6_mode_forced");
    exp_at(c + 10, SIG_FLT, 1, "t6_fault_sticky");
    exp_at(c + 10, SIG_MODE, 2, "t6_mode_sticky");
`else
    exp_at(c + 1, SIG_FLT, 0, "t6_fault_off");
    exp_at(c + 1, SIG_MODE, 0, "t6_mode_unaffected");
    exp_at(c + 3, SIG_MODE, 0, "t6_mode_unaffected_late");
`endif
    ns_light = 2'b10;
    ew_light = 2'b01;
    tick();
    ns_light = 2'b00;
    ew_light = 2'b00;
    run_to(c + 12);
    #2 rst_n = 1'b0;
    #1;
    check("t6_fault_reset", int'(fault), 0);
    check("t6_mode_reset", int'(mode), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    while (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
